beat_scheduler: RTL

Schedules the beat counters for four fixed tracks: background loop, "red light" call, win jingle and lose jingle. It queues track requests from game logic and arbitrates between them by priority. It generates the beat-rate tick and drives track select, beat index and mute toward the note ROM / tone generator. It replaces per-track free-running beat counters with a single shared sequencer.

---
 rtl/beat_scheduler_if.sv | 22 ++
 rtl/beat_scheduler.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/beat_scheduler_if.sv
// Request/control and playback-status bundle between game logic and beat_scheduler.
interface beat_scheduler_if;
  logic [3:0]  req;
  logic        stop;
  logic        pause;
  logic [1:0]  track;
  logic [11:0] ibeat;
  logic        playing;
  logic        mute;
  logic        done;
  logic [1:0]  done_id;

  modport master (
    output req, stop, pause,
    input  track, ibeat, playing, mute, done, done_id
  );

  modport slave (
    input  req, stop, pause,
    output track, ibeat, playing, mute, done, done_id
  );
endinterface

// File: rtl/beat_scheduler.sv
// Shared beat sequencer for four fixed tracks: request queue, priority arbitration, beat tick.
// Optional mid-track preemption by a higher-priority request: define BEAT_SCHED_PREEMPT_EN.
module beat_scheduler #(
  parameter int unsigned BEAT_DIV  = 6250000,
  parameter int unsigned LEN0      = 256,
  parameter int unsigned LEN1      = 64,
  parameter int unsigned LEN2      = 64,
  parameter int unsigned LEN3      = 128,
  parameter int unsigned LOOP0     = 1,
  parameter int unsigned GAP_BEATS = 2
) (
  input logic             clk,
  input logic             reset,
  beat_scheduler_if.slave bus
);

  localparam int unsigned DIV_W = $clog2(BEAT_DIV);

`ifdef BEAT_SCHED_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t           state;
  logic [3:0]       pending;
  logic [3:0]       clr;
  logic [3:0]       above;
  logic [DIV_W-1:0] divider;
  logic [3:0]       gap_cnt;
  logic [1:0]       track;
  logic [1:0]       winner;
  logic [1:0]       done_id;
  logic [11:0]      ibeat;
  logic [11:0]      last_beat;
  logic             playing;
  logic             mute_r;
  logic             done;
  logic             tick;
  logic             higher;
  logic             loop_here;

  always_comb begin
    winner = '0;
    for (int unsigned i = 0; i < 4; i++)
      if (pending[i]) winner = 2'(i);

    case (track)
      2'd0:    above = 4'b1110;
      2'd1:    above = 4'b1100;
      2'd2:    above = 4'b1000;
      default: above = 4'b0000;
    endcase
    higher = |(pending & above);

    case (track)
      2'd0:    last_beat = 12'(LEN0 - 1);
      2'd1:    last_beat = 12'(LEN1 - 1);
      2'd2:    last_beat = 12'(LEN2 - 1);
      default: last_beat = 12'(LEN3 - 1);
    endcase

    tick      = (divider == DIV_W'(BEAT_DIV - 1));
    loop_here = (LOOP0 != 0) && (track == 2'd0);

    // A looping track 0 keeps its bit so it resumes after anything that displaces it.
    clr = '0;
    if (state == IDLE && pending != '0 && !bus.pause && !((LOOP0 != 0) && winner == 2'd0))
      clr[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
      divider <= '0;
      gap_cnt <= '0;
      track   <= '0;
      ibeat   <= '0;
      playing <= 1'b0;
      mute_r  <= 1'b1;
      done    <= 1'b0;
      done_id <= '0;
    end else if (bus.stop) begin
      state   <= IDLE;
      pending <= '0;
      divider <= '0;
      gap_cnt <= '0;
      ibeat   <= '0;
      playing <= 1'b0;
      mute_r  <= 1'b1;
      done    <= 1'b0;
    end else begin
      done    <= 1'b0;
      pending <= (pending & ~clr) | bus.req;
      if (!bus.pause) begin
        case (state)
          IDLE: begin
            divider <= '0;
            if (pending != '0) begin
              state   <= PLAY;
              track   <= winner;
              ibeat   <= '0;
              playing <= 1'b1;
              mute_r  <= 1'b0;
            end
          end
          PLAY: begin
            if (PREEMPT && higher) begin
              state   <= IDLE;
              ibeat   <= '0;
              divider <= '0;
              playing <= 1'b0;
              mute_r  <= 1'b1;
            end else if (tick) begin
              divider <= '0;
              if (ibeat == last_beat) begin
                done    <= 1'b1;
                done_id <= track;
                ibeat   <= '0;
                if (!(loop_here && !higher)) begin
                  playing <= 1'b0;
                  mute_r  <= 1'b1;
                  gap_cnt <= '0;
                  state   <= (GAP_BEATS > 0) ? GAP : IDLE;
                end
              end else begin
                ibeat <= ibeat + 12'd1;
              end
            end else begin
              divider <= divider + 1'b1;
            end
          end
          GAP: begin
            if (tick) begin
              divider <= '0;
              if (gap_cnt == 4'(GAP_BEATS - 1)) state <= IDLE;
              else gap_cnt <= gap_cnt + 4'd1;
            end else begin
              divider <= divider + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.track   = track;
  assign bus.ibeat   = ibeat;
  assign bus.playing = playing;
  assign bus.mute    = mute_r | bus.pause;
  assign bus.done    = done;
  assign bus.done_id = done_id;

endmodule
